// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - registered two-port register-file write bus with long-latency drain FIFO
// Lanes own their ports outright; queued long-latency results fill idle ports in order.
module reg_write_arbiter #(
   parameter int LL_DEPTH = 4,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic                                wb_in_clk,
   input  logic                                wb_in_rst,
   input  logic                                wb_in_flush,
   input  logic                                l1_in_we,
   input  logic [ADDR_W-1:0]                   l1_in_waddr,
   input  logic [DATA_W-1:0]                   l1_in_wdata,
   input  logic                                l2_in_we,
   input  logic [ADDR_W-1:0]                   l2_in_waddr,
   input  logic [DATA_W-1:0]                   l2_in_wdata,
   input  logic                                ll_in_valid,
   input  logic [ADDR_W-1:0]                   ll_in_waddr,
   input  logic [DATA_W-1:0]                   ll_in_wdata,
   output logic                                ll_out_ready,
   output logic [2*(1+ADDR_W+DATA_W)-1:0]      write_obus,
   output logic [$clog2(LL_DEPTH):0]           ll_out_count,
   output logic [7:0]                          drop_out_cnt
);
   localparam int PTR_W  = $clog2(LL_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int PORT_W = 1 + ADDR_W + DATA_W;

   logic [ADDR_W-1:0]   addr_mem [LL_DEPTH];
   logic [DATA_W-1:0]   data_mem [LL_DEPTH];
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [7:0]          drop_q, drop_d;
   logic [8:0]          drop_sum;
   logic [2*PORT_W-1:0] bus_q, bus_d;

   logic                l1_act, l2_act, push, free1, free2, h0_hit, h1_hit;
   logic [1:0]          pops, drops;
   logic                p1_we, p2_we;
   logic [ADDR_W-1:0]   p1_addr, p2_addr, h0_addr, h1_addr;
   logic [DATA_W-1:0]   p1_data, p2_data, h0_data, h1_data;

   assign l1_act  = l1_in_we && (l1_in_waddr != '0);
   assign l2_act  = l2_in_we && (l2_in_waddr != '0);
   assign rd_nxt  = rd_ptr_q + PTR_W'(1);
   assign h0_addr = addr_mem[rd_ptr_q];
   assign h0_data = data_mem[rd_ptr_q];
   assign h1_addr = addr_mem[rd_nxt];
   assign h1_data = data_mem[rd_nxt];
   assign h0_hit  = (l1_act && h0_addr == l1_in_waddr) || (l2_act && h0_addr == l2_in_waddr);
   assign h1_hit  = (l1_act && h1_addr == l1_in_waddr) || (l2_act && h1_addr == l2_in_waddr);

   assign ll_out_ready = (count_q != CNT_W'(LL_DEPTH));
   assign ll_out_count = count_q;
   assign drop_out_cnt = drop_q;
   assign write_obus   = bus_q;

   always_comb begin
      p1_we   = l1_act;
      p1_addr = l1_act ? l1_in_waddr : '0;
      p1_data = l1_act ? l1_in_wdata : '0;
      p2_we   = l2_act;
      p2_addr = l2_act ? l2_in_waddr : '0;
      p2_data = l2_act ? l2_in_wdata : '0;
      free1   = !l1_act;
      free2   = !l2_act;
      pops    = 2'd0;
      drops   = 2'd0;
      push    = ll_in_valid && ll_out_ready && !wb_in_flush;

      // Head then head+1, in order: a colliding entry is discarded without using a port.
      if (!wb_in_flush && count_q != '0) begin
         if (h0_hit) begin
            pops  = 2'd1;
            drops = 2'd1;
         end else if (free1) begin
            {p1_we, p1_addr, p1_data} = {1'b1, h0_addr, h0_data};
            free1 = 1'b0;
            pops  = 2'd1;
         end else if (free2) begin
            {p2_we, p2_addr, p2_data} = {1'b1, h0_addr, h0_data};
            free2 = 1'b0;
            pops  = 2'd1;
         end
      end
      if (!wb_in_flush && count_q >= CNT_W'(2) && pops == 2'd1) begin
         if (h1_hit) begin
            pops  = 2'd2;
            drops = drops + 2'd1;
         end else if (free1) begin
            {p1_we, p1_addr, p1_data} = {1'b1, h1_addr, h1_data};
            pops  = 2'd2;
         end else if (free2) begin
            {p2_we, p2_addr, p2_data} = {1'b1, h1_addr, h1_data};
            pops  = 2'd2;
         end
      end

      bus_d    = {p2_we, p2_addr, p2_data, p1_we, p1_addr, p1_data};
      drop_sum = {1'b0, drop_q} + 9'(drops);
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (wb_in_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = rd_ptr_q + PTR_W'(pops);
         wr_ptr_d = wr_ptr_q + PTR_W'(push);
         count_d  = count_q + CNT_W'(push) - CNT_W'(pops);
      end
   end

   always_ff @(posedge wb_in_clk or posedge wb_in_rst) begin
      if (wb_in_rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
         bus_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
         bus_q    <= bus_d;
      end
   end

   always_ff @(posedge wb_in_clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= ll_in_waddr;
         data_mem[wr_ptr_q] <= ll_in_wdata;
      end
   end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - scoreboard bench for reg_write_arbiter
module tb_reg_write_arbiter;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int BW = 2 * (1 + AW + DW);

   logic          clk = 1'b0;
   logic          rst, flush;
   logic          l1_we, l2_we, ll_valid;
   logic [AW-1:0] l1_addr, l2_addr, ll_addr;
   logic [DW-1:0] l1_data, l2_data, ll_data;
   logic          ready;
   logic [BW-1:0] bus;
   logic [2:0]    count;
   logic [7:0]    drops;

   int            checks = 0;
   int            errors = 0;
   logic [BW-1:0] exp_q [$];
   logic [BW-1:0] exp_bus;

   reg_write_arbiter #(.LL_DEPTH(4), .ADDR_W(AW), .DATA_W(DW)) dut (
      .wb_in_clk(clk), .wb_in_rst(rst), .wb_in_flush(flush),
      .l1_in_we(l1_we), .l1_in_waddr(l1_addr), .l1_in_wdata(l1_data),
      .l2_in_we(l2_we), .l2_in_waddr(l2_addr), .l2_in_wdata(l2_data),
      .ll_in_valid(ll_valid), .ll_in_waddr(ll_addr), .ll_in_wdata(ll_data),
      .ll_out_ready(ready), .write_obus(bus), .ll_out_count(count), .drop_out_cnt(drops)
   );

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] mk(input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                                        input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      return {w2, a2, d2, w1, a1, d1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                        input logic v, input logic [AW-1:0] la, input logic [DW-1:0] ld);
      l1_we = w1; l1_addr = a1; l1_data = d1;
      l2_we = w2; l2_addr = a2; l2_data = d2;
      ll_valid = v; ll_addr = la; ll_data = ld;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      rst = 1'b0;
      exp_q.push_back('0);
      tick();
      exp_bus = exp_q.pop_front();
      checks++;
      if (bus !== exp_bus) begin errors++; $display("FAIL reset_bus: got %h expected %h", bus, exp_bus); end
      checks++;
      if (count !== 3'd0 || drops !== 8'd0 || ready !== 1'b1) begin
         errors++; $display("FAIL reset_state: count=%0d drops=%0d ready=%b expected 0 0 1", count, drops, ready);
      end
   endtask

   task automatic test_lanes();
      drive(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0);
      exp_q.push_back(mk(1, 4, 32'h22, 1, 3, 32'h11));
      tick();
      exp_bus = exp_q.pop_front();
      checks++;
      if (bus !== exp_bus || count !== 3'd0) begin
         errors++; $display("FAIL lanes_bus: got %h count %0d expected %h count 0", bus, count, exp_bus);
      end
   endtask

   task automatic test_ll_hold();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 32'h10 + i, 1, 2, 32'h20 + i, i == 0, 5, 32'hAA);
         exp_q.push_back(mk(1, 2, 32'h20 + i, 1, 1, 32'h10 + i));
         tick();
         exp_bus = exp_q.pop_front();
         checks++;
         if (bus !== exp_bus || count !== 3'd1) begin
            errors++; $display("FAIL hold_%0d: got %h count %0d expected %h count 1", i, bus, count, exp_bus);
         end
      end
      drive(0, 0, 0, 1, 2, 32'h77, 0, 0, 0);
      exp_q.push_back(mk(1, 2, 32'h77, 1, 5, 32'hAA));
      tick();
      exp_bus = exp_q.pop_front();
      checks++;
      if (bus !== exp_bus || count !== 3'd0) begin
         errors++; $display("FAIL hold_drain: got %h count %0d expected %h count 0", bus, count, exp_bus);
      end
   endtask

   task automatic test_full_pairs();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 32'h1, 1, 2, 32'h2, 1, AW'(10 + i), 32'h100 + i);
         tick();
         checks++;
         if (count !== 3'(i < 4 ? i + 1 : 4)) begin
            errors++; $display("FAIL fill_count_%0d: got %0d expected %0d", i, count, (i < 4 ? i + 1 : 4));
         end
      end
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", ready); end
      for (int p = 0; p < 2; p++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
         exp_q.push_back(mk(1, AW'(11 + 2 * p), 32'h101 + 2 * p, 1, AW'(10 + 2 * p), 32'h100 + 2 * p));
         tick();
         exp_bus = exp_q.pop_front();
         checks++;
         if (bus !== exp_bus || count !== 3'(2 - 2 * p)) begin
            errors++; $display("FAIL pair_%0d: got %h count %0d expected %h count %0d", p, bus, count, exp_bus, 2 - 2 * p);
         end
      end
      exp_q.push_back('0);
      tick();
      exp_bus = exp_q.pop_front();
      checks++;
      if (bus !== exp_bus || count !== 3'd0) begin
         errors++; $display("FAIL fifth_lost: got %h count %0d expected %h count 0", bus, count, exp_bus);
      end
   endtask

   task automatic test_waw_drop();
      drive(1, 1, 32'h1, 1, 2, 32'h2, 1, 7, 32'h1);
      tick();
      drive(0, 0, 0, 1, 7, 32'h2, 0, 0, 0);
      exp_q.push_back(mk(1, 7, 32'h2, 0, 0, 0));
      tick();
      exp_bus = exp_q.pop_front();
      checks++;
      if (bus !== exp_bus || count !== 3'd0 || drops !== 8'd1) begin
         errors++; $display("FAIL waw_drop: got %h count %0d drops %0d expected %h 0 1", bus, count, drops, exp_bus);
      end
   endtask

   task automatic test_zero_addr_lane();
      drive(1, 1, 32'h1, 1, 2, 32'h2, 1, 9, 32'h9);
      tick();
      drive(1, 0, 32'h55, 1, 2, 32'h2, 0, 0, 0);
      exp_q.push_back(mk(1, 2, 32'h2, 1, 9, 32'h9));
      tick();
      exp_bus = exp_q.pop_front();
      checks++;
      if (bus !== exp_bus || count !== 3'd0) begin
         errors++; $display("FAIL zero_addr: got %h count %0d expected %h count 0", bus, count, exp_bus);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 32'h1, 1, 2, 32'h2, 1, AW'(21 + i), 32'h200 + i);
         tick();
      end
      checks++;
      if (count !== 3'd3) begin errors++; $display("FAIL flush_pre: count %0d expected 3", count); end
      flush = 1'b1;
      drive(1, 6, 32'h66, 0, 0, 0, 1, 24, 32'h240);
      exp_q.push_back(mk(0, 0, 0, 1, 6, 32'h66));
      tick();
      flush = 1'b0;
      exp_bus = exp_q.pop_front();
      checks++;
      if (bus !== exp_bus || count !== 3'd0) begin
         errors++; $display("FAIL flush_cycle: got %h count %0d expected %h count 0", bus, count, exp_bus);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      exp_q.push_back('0);
      tick();
      exp_bus = exp_q.pop_front();
      checks++;
      if (bus !== exp_bus || count !== 3'd0) begin
         errors++; $display("FAIL flush_after: got %h count %0d expected %h count 0", bus, count, exp_bus);
      end
   endtask

   task automatic test_drop_saturate();
      for (int i = 0; i < 260; i++) begin
         drive(1, 1, 32'h1, 1, 2, 32'h2, 1, 1, 32'hDEAD);
         tick();
      end
      drive(1, 1, 32'h1, 1, 2, 32'h2, 0, 0, 0);
      tick();
      checks++;
      if (drops !== 8'd255 || count !== 3'd0) begin
         errors++; $display("FAIL drop_sat: drops %0d count %0d expected 255 0", drops, count);
      end
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 32'h1, 1, 2, 32'h2, 1, AW'(3 + i), 32'h300 + i);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      exp_q.push_back(mk(1, 4, 32'h301, 1, 3, 32'h300));
      tick();
      exp_bus = exp_q.pop_front();
      checks++;
      if (bus !== exp_bus || count !== 3'd1) begin
         errors++; $display("FAIL mid_drain: got %h count %0d expected %h count 1", bus, count, exp_bus);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus !== '0 || count !== 3'd0 || drops !== 8'd0 || ready !== 1'b1) begin
         errors++; $display("FAIL async_reset: bus %h count %0d drops %0d ready %b expected 0 0 0 1", bus, count, drops, ready);
      end
      #2 rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lanes();
      test_ll_hold();
      test_full_pairs();
      test_waw_drop();
      test_zero_addr_lane();
      test_flush();
      test_drop_saturate();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Writer-side companion of the dual-issue register file: it builds the registered two-port write bus that the register file consumes. Two in-order writeback lanes own write port 1 and write port 2 with absolute priority. Long-latency results (divider, uncached load) queue in a FIFO and drain into whichever ports the lanes leave idle. The block sits between the WB stage / long-latency units and the register file write inputs.

Parameters:
LL_DEPTH, 4, long-latency FIFO entries (power of two, >=2)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
wb_in_clk  input  1  clock, all state on rising edge
wb_in_rst  input  1  asynchronous, active-high reset
wb_in_flush  input  1  exception/ertn flush; empties FIFO
l1_in_we  input  1  lane1 write request
l1_in_waddr  input  ADDR_W  lane1 destination
l1_in_wdata  input  DATA_W  lane1 result
l2_in_we  input  1  lane2 write request
l2_in_waddr  input  ADDR_W  lane2 destination
l2_in_wdata  input  DATA_W  lane2 result
ll_in_valid  input  1  long-latency result offered
ll_in_waddr  input  ADDR_W  long-latency destination
ll_in_wdata  input  DATA_W  long-latency result
ll_out_ready  output  1  FIFO accepts (count != LL_DEPTH)
write_obus  output  2*(1+ADDR_W+DATA_W)  {we2,waddr2,wdata2,we1,waddr1,wdata1}, registered
ll_out_count  output  clog2(LL_DEPTH)+1  FIFO occupancy
drop_out_cnt  output  8  saturating count of discarded FIFO entries

Behaviour:
- Reset (async): write_obus all zero, FIFO empty, ll_out_count=0, drop_out_cnt=0, ll_out_ready=1.
- Lane active = we && waddr!=0. A lane with waddr 0 is idle and frees its port.
- Latency: one cycle. Inputs sampled at edge N appear on write_obus after edge N; the register file commits at edge N+1.
- Port mapping: lane1 always drives port1 and lane2 always drives port2 when active. Lanes are never stalled and never reordered. Lane1 and lane2 targeting the same address are both forwarded; the register file gives port2 priority.
- FIFO push: ll_in_valid && ll_out_ready. ll_out_ready is combinational from the current count only; a push into a full FIFO is not allowed even when a pop happens in the same cycle.
- FIFO drain, evaluated each cycle on the pre-push state:
  - Head takes port1 if lane1 is idle, else port2 if lane2 is idle.
  - If both lanes are idle and count>=2, the head goes to port1 and head+1 goes to port2. Two pops happen in that cycle.
  - An entry pushed in a cycle is not drainable until the next cycle; there is no bypass.
- WAW collision: if a drainable FIFO entry's address equals the address of any active lane in the same cycle, the lane data wins. That entry is popped without writing, drop_out_cnt increments by 1 (saturating at 255), and it does not consume a port. At most the head and head+1 are examined per cycle.
- Flush: FIFO pointers and count clear at the edge. A push in the flush cycle is ignored. Lane writes in the flush cycle still register normally, since upstream already filtered them. FIFO entries are not drained in the flush cycle.
- Pointers wrap modulo LL_DEPTH. Count is updated as count + push - pops.
- Unused port: we=0, waddr=0, wdata=0. There are no X values on the bus.
- Reset mid-drain: asynchronous clear, and write_obus drops to zero immediately.

Test Plan:
1. Reset, then lane1 we=1 waddr=3 wdata=0x11 and lane2 we=1 waddr=4 wdata=0x22 -> the next cycle write_obus shows port1=(1,3,0x11) and port2=(1,4,0x22); FIFO untouched.
2. Push LL (5,0xAA) while both lanes are busy for 3 cycles -> entry is held, count=1. In the first cycle with lane1 idle, port1=(1,5,0xAA) and count returns to 0.
3. Fill the FIFO with 4 entries, then offer a 5th -> ll_out_ready=0 and the 5th is not accepted. With both lanes idle, two cycles drain entries in pairs (port1 = older, port2 = younger) and count goes 4->2->0.
4. FIFO head (7,0x1) while lane2 writes (7,0x2) and lane1 is idle -> port2=(1,7,0x2), port1 we=0, the entry is popped and drop_out_cnt=1.
5. Three FIFO entries plus a flush asserted together with ll_in_valid -> count=0 after the edge, the new push is lost, and no FIFO data appears on write_obus.
6. Lane1 waddr=0 we=1 and FIFO head (9,0x9) -> the lane is treated as idle and port1=(1,9,0x9).
